// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU op codes, immediate formats and helpers for the RV32I ID stage
package decode_pkg;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
  } ctrl_t;
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [XLEN-1:0] imm_gen(input imm_fmt_e f, input logic [XLEN-1:0] i);
    case (f)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/decode_register_file.sv
// decode_register_file: 32x32 register file, two write-first bypassed read ports, x0 hardwired to zero
module decode_register_file import decode_pkg::*; (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);
  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic w_we;
  assign w_we = i_we && i_waddr != 5'd0;
  assign o_rdata1 = i_raddr1 == 5'd0 ? '0 : (w_we && i_waddr == i_raddr1) ? i_wdata : r_regs[i_raddr1];
  assign o_rdata2 = i_raddr2 == 5'd0 ? '0 : (w_we && i_waddr == i_raddr2) ? i_wdata : r_regs[i_raddr2];
  // write port; writes to x0 are dropped
  always_ff @(posedge clock) begin
    if (reset) r_regs <= '{default: '0};
    else if (w_we) r_regs[i_waddr] <= i_wdata;
  end
endmodule

// File: rtl/decode.sv
// decode: RV32I ID stage with register file, immediate generation, load-use stall and ID/EX register
module decode import decode_pkg::*; (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instrucao,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            load_pc,
  output logic            load_if_id_register,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [3:0]      alu_op,
  output logic            alu_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            branch,
  output logic            jump
);
  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_rdata1, w_rdata2;
  ctrl_t           w_ctrl;
  imm_fmt_e        w_fmt;
  logic            w_use1, w_use2, w_stall;
  ctrl_t           r_ctrl;
  logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  assign w_opcode = instrucao[6:0];
  assign w_f3     = instrucao[14:12];
  assign w_rs1    = instrucao[19:15];
  assign w_rs2    = instrucao[24:20];
  assign w_rd     = instrucao[11:7];
  decode_register_file u_rf (
    .clock    (clock),
    .reset    (reset),
    .i_we     (wb_reg_write),
    .i_waddr  (wb_rd),
    .i_wdata  (wb_data),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );
  // main decoder: control word, operand usage and immediate format; unknown opcodes stay a bubble
  always_comb begin
    w_ctrl = '0;
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    w_fmt  = IMM_NONE;
    case (w_opcode)
      OP_R:      begin w_ctrl.alu_op = alu_decode(w_f3, instrucao[30]); w_ctrl.reg_write = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
      OP_IMM:    begin w_ctrl.alu_op = alu_decode(w_f3, instrucao[30] && w_f3 == 3'd5); w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_use1 = 1'b1; w_fmt = IMM_I; end
      OP_LOAD:   begin w_ctrl.alu_src = 1'b1; w_ctrl.mem_read = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.mem_to_reg = 1'b1; w_use1 = 1'b1; w_fmt = IMM_I; end
      OP_STORE:  begin w_ctrl.alu_src = 1'b1; w_ctrl.mem_write = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; w_fmt = IMM_S; end
      OP_BRANCH: begin w_ctrl.alu_op = w_f3[2] ? (w_f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB; w_ctrl.branch = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; w_fmt = IMM_B; end
      OP_JAL:    begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.jump = 1'b1; w_fmt = IMM_J; end
      OP_JALR:   begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.jump = 1'b1; w_use1 = 1'b1; w_fmt = IMM_I; end
      OP_LUI:    begin w_ctrl.alu_op = ALU_PASSB; w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_fmt = IMM_U; end
      OP_AUIPC:  begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_fmt = IMM_U; end
      default:   ;
    endcase
  end
  // a load in EX whose destination is read here must wait one cycle; reset and flush override it
  assign w_stall = !reset && !flush && r_ctrl.mem_read && r_rd != 5'd0 &&
                   ((w_use1 && r_rd == w_rs1) || (w_use2 && r_rd == w_rs2));
  assign load_pc             = !w_stall;
  assign load_if_id_register = !w_stall;
  // ID/EX register; reset, flush and stall all load a cleared bubble
  always_ff @(posedge clock) begin
    if (reset || flush || w_stall) begin
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else begin
      r_ctrl     <= w_ctrl;
      r_pc       <= pc_in;
      r_rs1_data <= w_rdata1;
      r_rs2_data <= w_rdata2;
      r_imm      <= imm_gen(w_fmt, instrucao);
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
    end
  end
  assign pc_out     = r_pc;
  assign rs1_data   = r_rs1_data;
  assign rs2_data   = r_rs2_data;
  assign imm        = r_imm;
  assign rs1        = r_rs1;
  assign rs2        = r_rs2;
  assign rd         = r_rd;
  assign alu_op     = r_ctrl.alu_op;
  assign alu_src    = r_ctrl.alu_src;
  assign mem_read   = r_ctrl.mem_read;
  assign mem_write  = r_ctrl.mem_write;
  assign reg_write  = r_ctrl.reg_write;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign branch     = r_ctrl.branch;
  assign jump       = r_ctrl.jump;
endmodule

// File: tb/tb_decode.sv
// tb_decode: scoreboard bench for the RV32I ID stage
module tb_decode;
  import decode_pkg::*;
  typedef struct packed {
    logic [31:0] pc, d1, d2, im;
    logic [4:0]  a1, a2, ad;
    logic [3:0]  op;
    logic [6:0]  c;
  } idex_t;
  typedef struct { idex_t v; idex_t m; } sb_t;
  logic clock = 1'b0;
  logic reset, wb_reg_write, flush;
  logic [31:0] pc_in, instrucao, wb_data;
  logic [4:0]  wb_rd;
  logic load_pc, load_if_id_register, alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump;
  logic [31:0] pc_out, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  sb_t   q[$];
  idex_t m_all, m_ctl, m_imm, m_immrd;
  int n_cmp = 0, n_bad = 0;
  decode dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .instrucao(instrucao),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .load_pc(load_pc), .load_if_id_register(load_if_id_register),
    .pc_out(pc_out), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .alu_src(alu_src),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump)
  );
  always #5 clock = ~clock;
  function automatic idex_t mk(input logic [31:0] p, x1, x2, xi, input logic [4:0] b1, b2, bd,
                               input logic [3:0] o, input logic [6:0] cc);
    idex_t e;
    e.pc = p; e.d1 = x1; e.d2 = x2; e.im = xi; e.a1 = b1; e.a2 = b2; e.ad = bd; e.op = o; e.c = cc;
    return e;
  endfunction
  function automatic idex_t sample();
    return mk(pc_out, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_op,
              {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump});
  endfunction
  task automatic issue(input logic [31:0] ins, input logic [31:0] p, input idex_t e, input idex_t m);
    instrucao = ins;
    pc_in = p;
    q.push_back('{v: e, m: m});
  endtask
  task automatic test_reset();
    sb_t s; idex_t a;
    reset = 1'b1; flush = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    issue(32'h00012083, 32'h40, '0, m_all);
    @(posedge clock); #1;
    n_cmp++; if ({load_pc, load_if_id_register} !== 2'b11) begin n_bad++; $display("FAIL reset_load: got %b exp 11", {load_pc, load_if_id_register}); end
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL reset_idex: got %h exp %h", a & s.m, s.v & s.m); end
    reset = 1'b0;
  endtask
  task automatic test_addi();
    sb_t s; idex_t a;
    issue(32'h00000013, 32'h100, mk(32'h100, 0, 0, 0, 0, 0, 0, ALU_ADD, 7'b1001000), m_all);
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL addi: got %h exp %h", a & s.m, s.v & s.m); end
  endtask
  task automatic test_bypass();
    sb_t s; idex_t a;
    logic [31:0] ins [3];
    idex_t ex [3];
    ins = '{32'h00028333, 32'h005283B3, 32'h40028433};
    ex[0] = mk(32'h104, 32'hDEADBEEF, 0, 0, 5, 0, 6, ALU_ADD, 7'b0001000);
    ex[1] = mk(32'h108, 32'hDEADBEEF, 32'hDEADBEEF, 0, 5, 5, 7, ALU_ADD, 7'b0001000);
    ex[2] = mk(32'h10C, 32'hDEADBEEF, 0, 0, 5, 0, 8, ALU_SUB, 7'b0001000);
    for (int k = 0; k < 3; k++) begin
      wb_reg_write = (k == 0); wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      issue(ins[k], 32'h104 + 32'(4 * k), ex[k], m_all);
      @(posedge clock); #1;
      s = q.pop_front(); a = sample();
      n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL bypass[%0d]: got %h exp %h", k, a & s.m, s.v & s.m); end
    end
    wb_reg_write = 1'b0;
  endtask
  task automatic test_load_use();
    sb_t s; idex_t a;
    issue(32'h00012083, 32'h110, mk(32'h110, 0, 0, 0, 2, 0, 1, ALU_ADD, 7'b1101100), m_all);
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL lu_load: got %h exp %h", a & s.m, s.v & s.m); end
    wb_reg_write = 1'b1; wb_rd = 5'd4; wb_data = 32'hA5A5A5A5;
    issue(32'h004081B3, 32'h114, '0, m_ctl);
    #1;
    n_cmp++; if ({load_pc, load_if_id_register} !== 2'b00) begin n_bad++; $display("FAIL lu_stall: got %b exp 00", {load_pc, load_if_id_register}); end
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL lu_bubble: got %h exp %h", a & s.m, s.v & s.m); end
    wb_rd = 5'd1; wb_data = 32'h11112222;
    issue(32'h004081B3, 32'h114, mk(32'h114, 32'h11112222, 32'hA5A5A5A5, 0, 1, 4, 3, ALU_ADD, 7'b0001000), m_all);
    #1;
    n_cmp++; if ({load_pc, load_if_id_register} !== 2'b11) begin n_bad++; $display("FAIL lu_release: got %b exp 11", {load_pc, load_if_id_register}); end
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL lu_replay: got %h exp %h", a & s.m, s.v & s.m); end
    wb_reg_write = 1'b0;
  endtask
  task automatic test_x0();
    sb_t s; idex_t a;
    issue(32'h00012003, 32'h118, mk(32'h118, 0, 0, 0, 2, 0, 0, ALU_ADD, 7'b1101100), m_all);
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL x0_load: got %h exp %h", a & s.m, s.v & s.m); end
    issue(32'h004001B3, 32'h11C, mk(32'h11C, 0, 32'hA5A5A5A5, 0, 0, 4, 3, ALU_ADD, 7'b0001000), m_all);
    #1;
    n_cmp++; if ({load_pc, load_if_id_register} !== 2'b11) begin n_bad++; $display("FAIL x0_nostall: got %b exp 11", {load_pc, load_if_id_register}); end
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL x0_add: got %h exp %h", a & s.m, s.v & s.m); end
    for (int k = 0; k < 2; k++) begin
      wb_reg_write = (k == 0); wb_rd = 5'd0; wb_data = 32'h1234;
      issue(32'h000004B3, 32'h120 + 32'(4 * k), mk(32'h120 + 32'(4 * k), 0, 0, 0, 0, 0, 9, ALU_ADD, 7'b0001000), m_all);
      @(posedge clock); #1;
      s = q.pop_front(); a = sample();
      n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL x0_write[%0d]: got %h exp %h", k, a & s.m, s.v & s.m); end
    end
    wb_reg_write = 1'b0;
  endtask
  task automatic test_flush();
    sb_t s; idex_t a;
    issue(32'h00012083, 32'h128, mk(32'h128, 0, 0, 0, 2, 0, 1, ALU_ADD, 7'b1101100), m_all);
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL fl_load: got %h exp %h", a & s.m, s.v & s.m); end
    flush = 1'b1;
    issue(32'h004081B3, 32'h12C, '0, m_ctl);
    #1;
    n_cmp++; if ({load_pc, load_if_id_register} !== 2'b11) begin n_bad++; $display("FAIL fl_nostall: got %b exp 11", {load_pc, load_if_id_register}); end
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL fl_bubble: got %h exp %h", a & s.m, s.v & s.m); end
    flush = 1'b0;
    issue(32'h004081B3, 32'h130, mk(32'h130, 32'h11112222, 32'hA5A5A5A5, 0, 1, 4, 3, ALU_ADD, 7'b0001000), m_all);
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL fl_after: got %h exp %h", a & s.m, s.v & s.m); end
  endtask
  task automatic test_imm();
    sb_t s; idex_t a;
    logic [31:0] ins [5];
    idex_t ex [5], mm [5];
    ins = '{32'hFE000CE3, 32'h001000EF, 32'hFE512E23, 32'h12345537, 32'h00000000};
    ex[0] = mk(32'h134, 0, 0, 32'hFFFFFFF8, 0, 0, 0, 0, 7'b0000010);  mm[0] = m_imm;
    ex[1] = mk(32'h138, 0, 0, 32'h00000800, 0, 0, 1, 0, 7'b0001001);  mm[1] = m_immrd;
    ex[2] = mk(32'h13C, 0, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 7'b1010000);  mm[2] = m_imm;
    ex[3] = mk(32'h140, 0, 0, 32'h12345000, 0, 0, 10, 0, 7'b0001000); mm[3] = m_immrd;
    ex[4] = '0;                                                       mm[4] = m_ctl;
    for (int k = 0; k < 5; k++) begin
      issue(ins[k], 32'h134 + 32'(4 * k), ex[k], mm[k]);
      @(posedge clock); #1;
      s = q.pop_front(); a = sample();
      n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL imm[%0d]: got %h exp %h", k, a & s.m, s.v & s.m); end
    end
  endtask
  task automatic test_reset_mid_stall();
    sb_t s; idex_t a;
    issue(32'h00012083, 32'h150, mk(32'h150, 0, 0, 0, 2, 0, 1, ALU_ADD, 7'b1101100), m_all);
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL rs_load: got %h exp %h", a & s.m, s.v & s.m); end
    reset = 1'b1;
    issue(32'h004081B3, 32'h154, '0, m_all);
    #1;
    n_cmp++; if ({load_pc, load_if_id_register} !== 2'b11) begin n_bad++; $display("FAIL rs_load_ctl: got %b exp 11", {load_pc, load_if_id_register}); end
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL rs_clear: got %h exp %h", a & s.m, s.v & s.m); end
    reset = 1'b0;
    issue(32'h004081B3, 32'h154, mk(32'h154, 0, 0, 0, 1, 4, 3, ALU_ADD, 7'b0001000), m_all);
    #1;
    n_cmp++; if ({load_pc, load_if_id_register} !== 2'b11) begin n_bad++; $display("FAIL rs_release: got %b exp 11", {load_pc, load_if_id_register}); end
    @(posedge clock); #1;
    s = q.pop_front(); a = sample();
    n_cmp++; if ((a & s.m) !== (s.v & s.m)) begin n_bad++; $display("FAIL rs_add: got %h exp %h", a & s.m, s.v & s.m); end
  endtask
  initial begin
    m_all   = '1;
    m_ctl   = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 7'h7F);
    m_imm   = mk(0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 7'h3F);
    m_immrd = mk(32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 0, 0, 5'h1F, 0, 7'h3F);
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_x0();
    test_flush();
    test_imm();
    test_reset_mid_stall();
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d exp 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
